// File: rtl/debouncer.sv
// Push-button debouncer: qualifies a synchronous button level over DEBOUNCE_WAIT
// consecutive cycles and emits a registered one-cycle pulse on each debounced press.
module debouncer #(
  parameter int unsigned DEBOUNCE_WAIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_pls_out
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_WAIT - 1);

  logic             stable_r;
  logic             stable_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             pulse_r;
  logic             pulse_s;

  // Next-state logic: count cycles of disagreement; any agreement restarts qualification.
  always_comb begin
    stable_s = stable_r;
    count_s  = CNT_ZERO;
    pulse_s  = 1'b0;
    if (btn == stable_r) begin
      count_s = CNT_ZERO;
      pulse_s = 1'b0;
    end else if (count_r < CNT_LAST) begin
      count_s = count_r + CNT_ONE;
      pulse_s = 1'b0;
    end else begin
      // Only a rising debounced edge produces a pulse; a release updates silently.
      stable_s = btn;
      count_s  = CNT_ZERO;
      pulse_s  = btn;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 1'b0;
      count_r  <= CNT_ZERO;
      pulse_r  <= 1'b0;
    end else begin
      stable_r <= stable_s;
      count_r  <= count_s;
      pulse_r  <= pulse_s;
    end
  end

  assign btn_pls_out = pulse_r;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (DEBOUNCE_WAIT = 8): directed scenarios plus
// randomized bursts compared against a sliding-window reference model.
module tb_debouncer;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic btn;
  logic btn_pls_out;

  int total;
  int bad;

  // Reference model: the debounced level flips when the last W samples all differ from it.
  logic m_stable;
  logic m_pulse;
  logic hist[$];

  debouncer #(.DEBOUNCE_WAIT(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .btn_pls_out (btn_pls_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    hist.delete();
    m_stable = 1'b0;
    m_pulse  = 1'b0;
  endtask

  // Drive one sample, advance one edge, update the model, settle 1 ns past the edge.
  task automatic step(input logic b);
    logic all_diff;
    btn = b;
    @(posedge clk);
    m_pulse = 1'b0;
    if (rst_n) begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      if (hist.size() == W) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i] == m_stable) all_diff = 1'b0;
        if (all_diff) begin
          m_stable = b;
          m_pulse  = b;
        end
      end
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(0, 1)));
      total++;
      if (btn_pls_out !== 1'b0) begin
        bad++;
        $display("FAIL reset cycle %0d: got %0b want 0", i, btn_pls_out);
      end
    end
    btn   = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 60; i++) begin
      step(1'b1);
      total++;
      if (btn_pls_out !== (i == W)) begin
        bad++;
        $display("FAIL clean_press edge %0d: got %0b want %0b", i, btn_pls_out, (i == W));
      end
    end
  endtask

  task automatic test_release();
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      total++;
      if (btn_pls_out !== 1'b0 || dut.stable_r !== (i < W)) begin
        bad++;
        $display("FAIL release edge %0d: pulse=%0b stable=%0b want pulse=0 stable=%0b",
                 i, btn_pls_out, dut.stable_r, (i < W));
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 8; i++) begin
      step(i < 4);
      total++;
      if (btn_pls_out !== 1'b0 || dut.stable_r !== 1'b0) begin
        bad++;
        $display("FAIL glitch cycle %0d: pulse=%0b stable=%0b want 0/0", i, btn_pls_out, dut.stable_r);
      end
    end
  endtask

  task automatic test_near_threshold();
    for (int i = 1; i <= 16; i++) begin
      step(i != 8);
      total++;
      if (btn_pls_out !== (i == 16)) begin
        bad++;
        $display("FAIL near_threshold cycle %0d: got %0b want %0b", i, btn_pls_out, (i == 16));
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < W; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (btn_pls_out !== 1'b0 || dut.count_r !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset async: pulse=%0b count=%0d want 0/0", btn_pls_out, dut.count_r);
    end
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      total++;
      if (btn_pls_out !== (i == W)) begin
        bad++;
        $display("FAIL mid_reset edge %0d: got %0b want %0b", i, btn_pls_out, (i == W));
      end
    end
  endtask

  task automatic test_reset_during_pulse();
    for (int i = 0; i < W; i++) step(1'b0);
    for (int i = 0; i < W; i++) step(1'b1);
    total++;
    if (btn_pls_out !== 1'b1) begin
      bad++;
      $display("FAIL pulse_before_reset: got %0b want 1", btn_pls_out);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (btn_pls_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_during_pulse: got %0b want 0", btn_pls_out);
    end
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic lvl;
    int   run;
    int   pulses;
    pulses = 0;
    lvl    = 1'b0;
    for (int n = 0; n < 300; n++) begin
      lvl = ~lvl;
      run = $urandom_range(1, 12);
      for (int k = 0; k < run; k++) begin
        step(lvl);
        if (m_pulse) pulses++;
        total++;
        if (btn_pls_out !== m_pulse || dut.stable_r !== m_stable) begin
          bad++;
          $display("FAIL random burst %0d: pulse=%0b stable=%0b want pulse=%0b stable=%0b",
                   n, btn_pls_out, dut.stable_r, m_pulse, m_stable);
        end
      end
    end
    $display("random bursts produced %0d expected pulses", pulses);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    btn   = 1'b0;
    rst_n = 1'b0;
    model_clear();
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_near_threshold();
    test_mid_reset();
    test_reset_during_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
